// File: rtl/alu_ctrl.sv
// Command-side controller for an 8-bit combinational alu: accepts ALU/LI instructions,
// reads a 4 x 8-bit register file, drives the alu, writes back and reports each result.
module alu_ctrl #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [1:0]  alu_op,
    input  logic [7:0]  alu_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic [1:0]  res_rd,
    output logic        res_zero,
    output logic [7:0]  op_count,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);

    // Both channels are valid/ready: a transfer happens on the rising edge where
    // valid and ready are both high; valid holds its payload stable until then.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [1:0]      rd_q, rd_d;
    logic [3:0][7:0] rf_q, rf_d;
    logic [7:0]      alu_a_q, alu_a_d;
    logic [7:0]      alu_b_q, alu_b_d;
    logic [1:0]      alu_op_q, alu_op_d;
    logic [7:0]      res_data_q, res_data_d;
    logic [1:0]      res_rd_q, res_rd_d;
    logic [7:0]      op_count_q, op_count_d;
    logic            unused_instr_bit;

    assign unused_instr_bit = instr[14];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        rf_d       = rf_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        res_data_d = res_data_q;
        res_rd_d   = res_rd_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready) begin
                    if (instr[15]) begin
                        rf_d[instr[11:10]] = instr[7:0];
                        res_data_d         = instr[7:0];
                        res_rd_d           = instr[11:10];
                        state_d            = RESP;
                    end else begin
                        alu_a_d  = rf_q[instr[9:8]];
                        alu_b_d  = rf_q[instr[7:6]];
                        alu_op_d = instr[13:12];
                        rd_d     = instr[11:10];
                        cnt_d    = CNT_INIT;
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                // Operands have been stable for EXEC_CYCLES edges when cnt reaches 0.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rf_d[rd_q] = alu_result;
                    res_data_d = alu_result;
                    res_rd_d   = rd_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            rf_q       <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            rf_q       <= rf_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            res_data_q <= res_data_d;
            res_rd_q   <= res_rd_d;
            op_count_q <= op_count_d;
        end
    end

    assign instr_ready = (state_q == IDLE) && rst_n;
    assign res_valid   = (state_q == RESP);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign res_data    = res_data_q;
    assign res_rd      = res_rd_q;
    assign res_zero    = (res_data_q == 8'd0);
    assign op_count    = op_count_q;
    assign dbg_data    = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: one instance with a behavioural alu (EXEC_CYCLES=1) and one
// with a bench-driven alu_result (EXEC_CYCLES=4) for sampling-edge and reset-abort checks.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        instr_valid, instr_ready, res_valid, res_ready, res_zero;
    logic [15:0] instr;
    logic [7:0]  alu_a, alu_b, alu_result, res_data, op_count, dbg_data;
    logic [1:0]  alu_op, res_rd, dbg_sel;

    logic        instr_valid1, instr_ready1, res_valid1, res_ready1, res_zero1;
    logic [15:0] instr1;
    logic [7:0]  alu_a1, alu_b1, alu_result1, res_data1, op_count1, dbg_data1;
    logic [1:0]  alu_op1, res_rd1, dbg_sel1;

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] cnt_snap;

    always #5 clk = ~clk;

    alu_ctrl #(.EXEC_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
        .res_zero(res_zero), .op_count(op_count), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    alu_ctrl #(.EXEC_CYCLES(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid1), .instr_ready(instr_ready1),
        .instr(instr1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_result(alu_result1),
        .res_valid(res_valid1), .res_ready(res_ready1), .res_data(res_data1), .res_rd(res_rd1),
        .res_zero(res_zero1), .op_count(op_count1), .dbg_sel(dbg_sel1), .dbg_data(dbg_data1)
    );

    // Reference alu for dut0
    always_comb begin
        case (alu_op)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction to dut0 with res_ready high and check the response.
    task automatic do_instr(input string tag, input logic [15:0] w,
                            input logic [7:0] exp_data, input int exp_lat);
        int lat;
        bit done;
        @(negedge clk);
        chk({tag, "_ready"}, instr_ready, 1);
        instr       = w;
        instr_valid = 1'b1;
        res_ready   = 1'b1;
        lat  = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            lat++;
            if (res_valid) done = 1'b1;
            else if (!w[15]) chk({tag, "_op_held"}, alu_op, w[13:12]);
        end
        chk({tag, "_valid"}, done, 1);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, res_data, exp_data);
        chk({tag, "_rd"}, res_rd, w[11:10]);
        chk({tag, "_zero"}, res_zero, exp_data == 8'd0);
        @(negedge clk);
        chk({tag, "_done"}, res_valid, 0);
    endtask

    task automatic chk_regs_zero(input string tag);
        for (int r = 0; r < 4; r++) begin
            dbg_sel  = 2'(r);
            dbg_sel1 = 2'(r);
            #1;
            chk({tag, "_rf0"}, dbg_data, 0);
            chk({tag, "_rf1"}, dbg_data1, 0);
        end
    endtask

    initial begin
        instr_valid  = 0; instr  = '0; res_ready  = 0; dbg_sel  = '0;
        instr_valid1 = 0; instr1 = '0; res_ready1 = 0; dbg_sel1 = '0; alu_result1 = '0;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", instr_ready, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_opcnt", op_count, 0);
        rst_n = 1'b1;

        // LI r0,10; LI r1,5; ADD r2,r0,r1 -> 15
        do_instr("li_r0_10", 16'h800A, 8'd10, 1);
        do_instr("li_r1_5", 16'h8405, 8'd5, 1);
        do_instr("add_15", 16'h0840, 8'd15, 2);
        dbg_sel = 2'd2; #1;
        chk("dbg_r2_15", dbg_data, 8'd15);
        chk("opcnt_3", op_count, 8'd3);

        // Wrap-around arithmetic
        do_instr("li_r0_200", 16'h80C8, 8'd200, 1);
        do_instr("li_r1_100", 16'h8464, 8'd100, 1);
        do_instr("add_wrap", 16'h0C40, 8'd44, 2);
        do_instr("sub_wrap", 16'h1D00, 8'd156, 2);
        do_instr("sub_zero", 16'h1940, 8'd0, 2);

        // Logic ops, alu_op held through EXEC and afterwards
        do_instr("li_r0_cc", 16'h80CC, 8'hCC, 1);
        do_instr("li_r1_aa", 16'h84AA, 8'hAA, 1);
        do_instr("and", 16'h2840, 8'h88, 2);
        do_instr("or", 16'h3C40, 8'hEE, 2);
        chk("op_held_idle", alu_op, 2'b11);

        // Response back-pressure; a second instruction offered meanwhile is ignored
        @(negedge clk);
        instr = 16'h8C5A; instr_valid = 1'b1; res_ready = 1'b0;
        @(negedge clk);
        instr = 16'h8011;
        cnt_snap = op_count;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", res_valid, 1);
            chk("bp_data", res_data, 8'h5A);
            chk("bp_ready", instr_ready, 0);
            @(negedge clk);
        end
        res_ready = 1'b1; instr_valid = 1'b0;
        @(negedge clk);
        chk("bp_release", res_valid, 0);
        chk("bp_opcnt", op_count, 8'(cnt_snap + 8'd1));
        chk("bp_idle", instr_ready, 1);
        dbg_sel = 2'd0; #1;
        chk("bp_r0_kept", dbg_data, 8'hCC);
        dbg_sel = 2'd3; #1;
        chk("bp_r3", dbg_data, 8'h5A);

        // EXEC_CYCLES=4: only the value on the 4th EXEC edge is captured
        @(negedge clk);
        instr1 = 16'h0400; instr_valid1 = 1'b1; res_ready1 = 1'b0;
        @(negedge clk); instr_valid1 = 1'b0; alu_result1 = 8'h11;
        chk("ex4_busy1", res_valid1, 0);
        @(negedge clk); alu_result1 = 8'h22;
        @(negedge clk); alu_result1 = 8'h33;
        @(negedge clk); alu_result1 = 8'h44;
        chk("ex4_busy4", res_valid1, 0);
        @(negedge clk);
        chk("ex4_valid", res_valid1, 1);
        chk("ex4_data", res_data1, 8'h44);
        chk("ex4_rd", res_rd1, 2'd1);
        alu_result1 = 8'h55; res_ready1 = 1'b1;
        @(negedge clk);
        chk("ex4_done", res_valid1, 0);
        chk("ex4_opcnt", op_count1, 8'd1);
        dbg_sel1 = 2'd1; #1;
        chk("ex4_r1", dbg_data1, 8'h44);

        // Reset during EXEC aborts the instruction
        @(negedge clk);
        instr1 = 16'h0800; instr_valid1 = 1'b1; res_ready1 = 1'b1;
        @(negedge clk); instr_valid1 = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rexec_ready", instr_ready1, 0);
        chk("rexec_valid", res_valid1, 0);
        @(negedge clk); rst_n = 1'b1;
        chk_regs_zero("rexec");
        chk("rexec_opcnt0", op_count, 0);
        chk("rexec_opcnt1", op_count1, 0);

        // Reset during RESP
        @(negedge clk);
        instr = 16'h8C77; instr_valid = 1'b1; res_ready = 1'b0;
        @(negedge clk); instr_valid = 1'b0;
        chk("rresp_pre", res_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rresp_valid", res_valid, 0);
        chk("rresp_ready", instr_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        chk_regs_zero("rresp");
        chk("rresp_opcnt", op_count, 0);
        chk("rresp_alu_a", alu_a, 0);
        chk("rresp_data", res_data, 0);

        // op_count wrap
        for (int i = 0; i < 255; i++) begin
            do_instr("wrap_li", 16'h8000 | 16'(i), 8'(i), 1);
        end
        chk("opcnt_255", op_count, 8'd255);
        do_instr("wrap_last", 16'h80FF, 8'hFF, 1);
        chk("opcnt_wrap", op_count, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
